levenshtein_controller_wide: RTL and testbench

Parametrised successor of the single-pattern Levenshtein search controller. Exposes a Wishbone slave register file and scans a byte-wide dictionary in external SRAM over a Wishbone master. For each character it fetches a BITVECTOR_WIDTH-bit pattern-match vector and runs one Myers bit-parallel step. Per search it reports the best (distance, index) pair and the count of words within a programmable distance threshold, with a programmable dictionary base, explicit done/error status and abort.

---
 rtl/levenshtein_pkg.sv | 33 +++
 rtl/levenshtein_controller_wide_myers_step.sv | 40 ++++
 rtl/levenshtein_controller_wide.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_levenshtein_controller_wide.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/levenshtein_pkg.sv
// Shared definitions for the wide Levenshtein dictionary search controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package levenshtein_pkg;

  // Slave register map, decoded from wbs_adr_i[3:0]
  localparam logic [3:0] REG_CTRL       = 4'h0;
  localparam logic [3:0] REG_SRAM_CTRL  = 4'h1;
  localparam logic [3:0] REG_LENGTH     = 4'h2;
  localparam logic [3:0] REG_THRESHOLD  = 4'h3;
  localparam logic [3:0] REG_DISTANCE   = 4'h4;
  localparam logic [3:0] REG_INDEX_HI   = 4'h5;
  localparam logic [3:0] REG_INDEX_LO   = 4'h6;
  localparam logic [3:0] REG_MATCHES_HI = 4'h7;
  localparam logic [3:0] REG_MATCHES_LO = 4'h8;
  localparam logic [3:0] REG_BASE_HI    = 4'h9;
  localparam logic [3:0] REG_BASE_MID   = 4'hA;
  localparam logic [3:0] REG_BASE_LO    = 4'hB;

  // Dictionary stream markers
  localparam logic [7:0] WORD_TERMINATOR = 8'h00;
  localparam logic [7:0] DICT_TERMINATOR = 8'h01;

  localparam logic [23:0] DEFAULT_DICT_BASE = 24'h000400;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_DICT = 2'd1,
    ST_READ_VEC  = 2'd2,
    ST_STEP      = 2'd3
  } state_t;

endpackage

// File: rtl/levenshtein_controller_wide_myers_step.sv
// One Myers bit-parallel edit-distance column update.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to register the results.
// Ports: i_pm/i_vp/i_vn  - match vector and current vertical delta vectors
//        i_mask          - one-hot bit marking the last pattern position
//        o_next_vp/o_next_vn - updated delta vectors
//        o_inc/o_dec     - distance moves up/down by one for this character
module myers_step #(
  parameter int BITVECTOR_WIDTH = 32
) (
  input  logic [BITVECTOR_WIDTH-1:0] i_pm,
  input  logic [BITVECTOR_WIDTH-1:0] i_vp,
  input  logic [BITVECTOR_WIDTH-1:0] i_vn,
  input  logic [BITVECTOR_WIDTH-1:0] i_mask,
  output logic [BITVECTOR_WIDTH-1:0] o_next_vp,
  output logic [BITVECTOR_WIDTH-1:0] o_next_vn,
  output logic                       o_inc,
  output logic                       o_dec
);

  localparam logic [BITVECTOR_WIDTH-1:0] ONE = {{(BITVECTOR_WIDTH-1){1'b0}}, 1'b1};

  logic [BITVECTOR_WIDTH-1:0] w_d0;
  logic [BITVECTOR_WIDTH-1:0] w_hp;
  logic [BITVECTOR_WIDTH-1:0] w_hn;
  logic [BITVECTOR_WIDTH-1:0] w_hp_sh;

  // Sums are kept at vector width; the carry out of the top bit is dropped.
  assign w_d0      = (((i_pm & i_vp) + i_vp) ^ i_vp) | i_pm | i_vn;
  assign w_hp      = i_vn | ~(w_d0 | i_vp);
  assign w_hn      = w_d0 & i_vp;
  // Shifting a 1 in at bit 0 models the top row growing by one per text
  // character, which yields a global (whole-word) edit distance.
  assign w_hp_sh   = (w_hp << 1) | ONE;
  assign o_next_vp = (w_hn << 1) | ~(w_d0 | w_hp_sh);
  assign o_next_vn = w_d0 & w_hp_sh;
  assign o_inc     = |(w_hp & i_mask);
  assign o_dec     = |(w_hn & i_mask);

endmodule

// File: rtl/levenshtein_controller_wide.sv
// Scans a byte dictionary over a Wishbone master and scores each word against a pattern.
// Latency: per char 1 dict read + BITVECTOR_WIDTH/8 vector reads + 1 step cycle.
// Backpressure: master reads stall until ack/err/rty; slave acks one cycle after each strobe.
// Ports: clk_i/rst_i clock and async active-high reset; wbm_* byte-wide read-only
//        Wishbone master to SRAM; wbs_* byte-wide Wishbone slave register file;
//        sram_config mirrors SRAM_CTRL[1:0].
module levenshtein_controller_wide #(
  parameter int MASTER_ADDR_WIDTH = 24,
  parameter int SLAVE_ADDR_WIDTH  = 24,
  parameter int BITVECTOR_WIDTH   = 32,
  parameter int ID_WIDTH          = 16,
  parameter int VECTOR_BASE       = 'h200
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         wbm_cyc_o,
  output logic                         wbm_stb_o,
  output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
  output logic                         wbm_we_o,
  output logic [7:0]                   wbm_dat_o,
  input  logic                         wbm_ack_i,
  input  logic                         wbm_err_i,
  input  logic                         wbm_rty_i,
  input  logic [7:0]                   wbm_dat_i,
  input  logic                         wbs_cyc_i,
  input  logic                         wbs_stb_i,
  input  logic                         wbs_we_i,
  input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
  input  logic [7:0]                   wbs_dat_i,
  output logic                         wbs_ack_o,
  output logic                         wbs_err_o,
  output logic                         wbs_rty_o,
  output logic [7:0]                   wbs_dat_o,
  output logic [1:0]                   sram_config
);

  import levenshtein_pkg::*;

  localparam int MAW = MASTER_ADDR_WIDTH;
  localparam int W   = BITVECTOR_WIDTH;
  localparam int NB  = BITVECTOR_WIDTH / 8;
  localparam logic [2:0] K_LAST = 3'(NB - 1);
  localparam logic [7:0] LMAX   = 8'(W - 1);

  state_t r_state;
  state_t w_state_next;

  logic           r_busy, r_done, r_error;
  logic           r_cyc;
  logic           r_wbs_ack;
  logic [1:0]     r_sram_cfg;
  logic [7:0]     r_length;     // pattern length - 1
  logic [7:0]     r_threshold;
  logic [7:0]     r_best_dist;
  logic [7:0]     r_d;
  logic [7:0]     r_ch;
  logic [2:0]     r_k;
  logic [ID_WIDTH-1:0] r_idx, r_best_idx, r_matches;
  logic [23:0]    r_dict_base;
  logic [MAW-1:0] r_addr;
  logic [W-1:0]   r_pm, r_vp, r_vn;

  logic           w_slv_req, w_slv_wr, w_start, w_abort;
  logic           w_m_ack, w_m_fail;
  logic [7:0]     w_len_wr;
  logic [7:0]     w_d_init;
  logic [W-1:0]   w_vp_init, w_mask;
  logic [W-1:0]   w_next_vp, w_next_vn;
  logic           w_inc, w_dec;
  logic [MAW-1:0] w_vec_adr;
  logic [MAW-1:0] w_adr;
  logic [7:0]     w_rdat;
  logic [15:0]    w_best_idx16, w_matches16;
  logic           w_unused;

  // ---------------- slave side decode ----------------
  assign w_slv_req = wbs_cyc_i & wbs_stb_i & ~r_wbs_ack;
  assign w_slv_wr  = w_slv_req & wbs_we_i;
  assign w_start   = w_slv_wr & (wbs_adr_i[3:0] == REG_CTRL) &  wbs_dat_i[0];
  assign w_abort   = w_slv_wr & (wbs_adr_i[3:0] == REG_CTRL) & ~wbs_dat_i[0];
  assign w_len_wr  = (wbs_dat_i >= 8'(W)) ? LMAX : wbs_dat_i;

  // Master terminations only count while a cycle is actually outstanding.
  assign w_m_ack  = r_cyc & wbm_ack_i;
  assign w_m_fail = r_cyc & (wbm_err_i | wbm_rty_i);

  // ---------------- per-word Myers initial state ----------------
  assign w_d_init  = r_length + 8'd1;
  assign w_vp_init = {W{1'b1}} >> (LMAX - r_length);
  assign w_mask    = {{(W-1){1'b0}}, 1'b1} << r_length;

  assign w_vec_adr = MAW'(VECTOR_BASE) + MAW'(r_ch) * MAW'(NB) + MAW'(r_k);

  myers_step #(.BITVECTOR_WIDTH(W)) u_step (
    .i_pm      (r_pm),
    .i_vp      (r_vp),
    .i_vn      (r_vn),
    .i_mask    (w_mask),
    .o_next_vp (w_next_vp),
    .o_next_vn (w_next_vn),
    .o_inc     (w_inc),
    .o_dec     (w_dec)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = ST_READ_DICT;
    end else if (w_abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_READ_DICT: begin
          if (w_m_fail) begin
            w_state_next = ST_IDLE;
          end else if (w_m_ack) begin
            if (wbm_dat_i == DICT_TERMINATOR)      w_state_next = ST_IDLE;
            else if (wbm_dat_i != WORD_TERMINATOR) w_state_next = ST_READ_VEC;
          end
        end
        ST_READ_VEC: begin
          if (w_m_fail)                       w_state_next = ST_IDLE;
          else if (w_m_ack && r_k == K_LAST)  w_state_next = ST_STEP;
        end
        ST_STEP: w_state_next = ST_READ_DICT;
        default: w_state_next = r_state;
      endcase
    end
  end

  // ---------------- datapath / search state ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cyc       <= 1'b0;
      r_sram_cfg  <= 2'b0;
      r_length    <= 8'h00;
      r_threshold <= 8'h00;
      r_best_dist <= 8'hFF;
      r_d         <= 8'h00;
      r_ch        <= 8'h00;
      r_k         <= 3'd0;
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_matches   <= '0;
      r_dict_base <= DEFAULT_DICT_BASE;
      r_addr      <= '0;
      r_pm        <= '0;
      r_vp        <= '0;
      r_vn        <= '0;
    end else begin
      if (w_slv_wr) begin
        case (wbs_adr_i[3:0])
          REG_SRAM_CTRL: r_sram_cfg          <= wbs_dat_i[1:0];
          REG_LENGTH:    r_length            <= w_len_wr;
          REG_THRESHOLD: r_threshold         <= wbs_dat_i;
          REG_BASE_HI:   r_dict_base[23:16]  <= wbs_dat_i;
          REG_BASE_MID:  r_dict_base[15:8]   <= wbs_dat_i;
          REG_BASE_LO:   r_dict_base[7:0]    <= wbs_dat_i;
          default: ;
        endcase
      end

      // Start/abort win over any master termination in the same cycle.
      if (w_start) begin
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
        r_cyc       <= 1'b0;
        r_addr      <= r_dict_base[MAW-1:0];
        r_idx       <= '0;
        r_matches   <= '0;
        r_best_dist <= 8'hFF;
        r_best_idx  <= '0;
        r_vp        <= w_vp_init;
        r_vn        <= '0;
        r_d         <= w_d_init;
      end else if (w_abort) begin
        r_busy <= 1'b0;
        r_cyc  <= 1'b0;
      end else begin
        case (r_state)
          ST_READ_DICT, ST_READ_VEC: begin
            if (!r_cyc) begin
              // One idle cycle after entering (or re-entering) a read state.
              r_cyc <= 1'b1;
            end else if (w_m_fail) begin
              r_cyc   <= 1'b0;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end else if (w_m_ack) begin
              r_cyc <= 1'b0;
              if (r_state == ST_READ_DICT) begin
                if (wbm_dat_i == WORD_TERMINATOR) begin
                  if (r_d < r_best_dist) begin
                    r_best_dist <= r_d;
                    r_best_idx  <= r_idx;
                  end
                  if (r_d <= r_threshold && r_matches != {ID_WIDTH{1'b1}})
                    r_matches <= r_matches + 1'b1;
                  r_idx  <= r_idx + 1'b1;
                  r_vp   <= w_vp_init;
                  r_vn   <= '0;
                  r_d    <= w_d_init;
                  r_addr <= r_addr + 1'b1;
                end else if (wbm_dat_i == DICT_TERMINATOR) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
                end else begin
                  r_ch   <= wbm_dat_i;
                  r_k    <= 3'd0;
                  r_addr <= r_addr + 1'b1;
                end
              end else begin
                // Vector bytes arrive most-significant first.
                r_pm <= (r_pm << 8) | W'(wbm_dat_i);
                r_k  <= r_k + 3'd1;
              end
            end
          end
          ST_STEP: begin
            r_vp <= w_next_vp;
            r_vn <= w_next_vn;
            if (w_inc) begin
              if (r_d != 8'hFF) r_d <= r_d + 8'd1;
            end else if (w_dec) begin
              if (r_d != 8'h00) r_d <= r_d - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_wbs_ack <= 1'b0;
    else       r_wbs_ack <= wbs_cyc_i & wbs_stb_i & ~r_wbs_ack;
  end

  // ---------------- outputs ----------------
  always_comb begin
    w_adr = '0;
    case (r_state)
      ST_READ_DICT: w_adr = r_addr;
      ST_READ_VEC:  w_adr = w_vec_adr;
      default:      w_adr = '0;
    endcase
  end

  assign w_best_idx16 = 16'(r_best_idx);
  assign w_matches16  = 16'(r_matches);

  always_comb begin
    w_rdat = 8'h00;
    case (wbs_adr_i[3:0])
      REG_CTRL:       w_rdat = {5'b0, r_error, r_done, r_busy};
      REG_SRAM_CTRL:  w_rdat = {6'b0, r_sram_cfg};
      REG_LENGTH:     w_rdat = r_length;
      REG_THRESHOLD:  w_rdat = r_threshold;
      REG_DISTANCE:   w_rdat = r_best_dist;
      REG_INDEX_HI:   w_rdat = w_best_idx16[15:8];
      REG_INDEX_LO:   w_rdat = w_best_idx16[7:0];
      REG_MATCHES_HI: w_rdat = w_matches16[15:8];
      REG_MATCHES_LO: w_rdat = w_matches16[7:0];
      REG_BASE_HI:    w_rdat = r_dict_base[23:16];
      REG_BASE_MID:   w_rdat = r_dict_base[15:8];
      REG_BASE_LO:    w_rdat = r_dict_base[7:0];
      default:        w_rdat = 8'h00;
    endcase
  end

  // Upper slave address bits and any dict-base bits above the master width are ignored.
  assign w_unused = ^{wbs_adr_i, r_dict_base};

  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_adr_o   = w_adr;
  assign wbm_we_o    = 1'b0;
  assign wbm_dat_o   = 8'h00;
  assign wbs_ack_o   = r_wbs_ack;
  assign wbs_err_o   = 1'b0;
  assign wbs_rty_o   = 1'b0;
  assign wbs_dat_o   = w_rdat;
  assign sram_config = r_sram_cfg;

endmodule

// File: tb/tb_levenshtein_controller_wide.sv
module tb_levenshtein_controller_wide;
  import levenshtein_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared slave bus, steered to one DUT by s_sel (0: 16-bit, 1: 32-bit)
  logic        s_cyc = 0, s_stb = 0, s_we = 0, s_sel = 0;
  logic [23:0] s_adr = '0;
  logic [7:0]  s_dat = '0;
  logic        s_ack;
  logic [7:0]  s_rdat;

  logic        a_cyc16, a_cyc32, a_ack16, a_ack32, a_err16, a_err32, a_rty16, a_rty32;
  logic [7:0]  a_rd16, a_rd32;
  logic [1:0]  cfg16, cfg32;
  assign a_cyc16 = s_cyc & ~s_sel;
  assign a_cyc32 = s_cyc &  s_sel;
  assign s_ack   = s_sel ? a_ack32 : a_ack16;
  assign s_rdat  = s_sel ? a_rd32  : a_rd16;

  // Master side, one SRAM model per DUT
  logic        m16_cyc, m16_stb, m16_we, m32_cyc, m32_stb, m32_we;
  logic [23:0] m16_adr, m32_adr;
  logic [7:0]  m16_wdat, m32_wdat;
  logic        m16_ack = 0, m16_err = 0, m32_ack = 0, m32_err = 0;
  logic [7:0]  m16_dat = 0, m32_dat = 0;
  logic [7:0]  mem16 [0:4095];
  logic [7:0]  mem32 [0:4095];
  int          rd16 = 0, rd32 = 0, err_at16 = 0;
  logic [7:0]  q[$];

  levenshtein_controller_wide #(.BITVECTOR_WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst),
    .wbm_cyc_o(m16_cyc), .wbm_stb_o(m16_stb), .wbm_adr_o(m16_adr), .wbm_we_o(m16_we),
    .wbm_dat_o(m16_wdat), .wbm_ack_i(m16_ack), .wbm_err_i(m16_err), .wbm_rty_i(1'b0),
    .wbm_dat_i(m16_dat),
    .wbs_cyc_i(a_cyc16), .wbs_stb_i(s_stb), .wbs_we_i(s_we), .wbs_adr_i(s_adr),
    .wbs_dat_i(s_dat), .wbs_ack_o(a_ack16), .wbs_err_o(a_err16), .wbs_rty_o(a_rty16),
    .wbs_dat_o(a_rd16), .sram_config(cfg16)
  );

  levenshtein_controller_wide #(.BITVECTOR_WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst),
    .wbm_cyc_o(m32_cyc), .wbm_stb_o(m32_stb), .wbm_adr_o(m32_adr), .wbm_we_o(m32_we),
    .wbm_dat_o(m32_wdat), .wbm_ack_i(m32_ack), .wbm_err_i(m32_err), .wbm_rty_i(1'b0),
    .wbm_dat_i(m32_dat),
    .wbs_cyc_i(a_cyc32), .wbs_stb_i(s_stb), .wbs_we_i(s_we), .wbs_adr_i(s_adr),
    .wbs_dat_i(s_dat), .wbs_ack_o(a_ack32), .wbs_err_o(a_err32), .wbs_rty_o(a_rty32),
    .wbs_dat_o(a_rd32), .sram_config(cfg32)
  );

  // SRAM responders: one-cycle registered ack, optional error on a chosen read number
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m16_ack <= 0; m16_err <= 0;
    end else if (m16_cyc && m16_stb && !m16_ack && !m16_err) begin
      rd16 <= rd16 + 1;
      if (rd16 + 1 == err_at16) m16_err <= 1;
      else begin m16_ack <= 1; m16_dat <= mem16[m16_adr[11:0]]; end
    end else begin
      m16_ack <= 0; m16_err <= 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m32_ack <= 0; m32_err <= 0;
    end else if (m32_cyc && m32_stb && !m32_ack && !m32_err) begin
      rd32 <= rd32 + 1;
      m32_ack <= 1; m32_dat <= mem32[m32_adr[11:0]];
    end else begin
      m32_ack <= 0; m32_err <= 0;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wb_write(input logic u, input logic [3:0] a, input logic [7:0] d);
    bit got;
    got = 0;
    @(negedge clk);
    s_sel = u; s_adr = {20'h0, a}; s_dat = d; s_we = 1; s_cyc = 1; s_stb = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (s_ack) begin got = 1; break; end
    end
    s_cyc = 0; s_stb = 0; s_we = 0;
    if (!got) begin checks++; errors++; $display("FAIL slave_write_ack adr=%0h no ack, ack required", a); end
  endtask

  task automatic wb_read(input logic u, input logic [3:0] a, output logic [7:0] d);
    bit got;
    got = 0; d = 8'hxx;
    @(negedge clk);
    s_sel = u; s_adr = {20'h0, a}; s_we = 0; s_cyc = 1; s_stb = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (s_ack) begin got = 1; d = s_rdat; break; end
    end
    s_cyc = 0; s_stb = 0;
    if (!got) begin checks++; errors++; $display("FAIL slave_read_ack adr=%0h no ack, ack required", a); end
  endtask

  task automatic wait_done(input logic u);
    logic [7:0] v;
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      wb_read(u, REG_CTRL, v);
      if (!v[0]) begin ok = 1; break; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL wait_done busy still 1, required 0"); end
  endtask

  task automatic load16(input int base);
    for (int i = 0; i < q.size(); i++) mem16[base + i] = q[i];
  endtask

  task automatic read16(input logic u, input logic [3:0] hi, output logic [15:0] v);
    logic [7:0] h, l;
    wb_read(u, hi, h);
    wb_read(u, hi + 4'd1, l);
    v = {h, l};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] v;
    for (int i = 0; i < 4096; i++) begin mem16[i] = 8'h00; mem32[i] = 8'h00; end
    // pattern "AB": 'A' -> 0x0001, 'B' -> 0x0002, MSB byte first
    mem16[12'h200 + 8'h41*2 + 1] = 8'h01;
    mem16[12'h200 + 8'h42*2 + 1] = 8'h02;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    checks++; if (m16_cyc !== 1'b0 || m16_adr !== 24'h0) begin errors++; $display("FAIL reset_master cyc=%b adr=%h required 0/0", m16_cyc, m16_adr); end
    checks++; if (m16_we !== 1'b0 || m16_wdat !== 8'h00 || a_err16 !== 1'b0 || a_rty16 !== 1'b0) begin errors++; $display("FAIL reset_tied we=%b dat=%h err=%b rty=%b required 0", m16_we, m16_wdat, a_err16, a_rty16); end
    wb_read(0, REG_CTRL, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h required 00", v); end
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL reset_distance got %h required FF", v); end
    wb_read(0, REG_THRESHOLD, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_threshold got %h required 00", v); end
    wb_read(0, REG_BASE_MID, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL reset_dict_base_mid got %h required 04", v); end
    wb_read(0, REG_BASE_LO, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_dict_base_lo got %h required 00", v); end
    checks++; if (cfg16 !== 2'b00) begin errors++; $display("FAIL reset_sram_config got %b required 00", cfg16); end
    wb_write(0, REG_SRAM_CTRL, 8'h02);
    #1;
    checks++; if (cfg16 !== 2'b10) begin errors++; $display("FAIL sram_config_out got %b required 10", cfg16); end
    wb_write(0, 4'hC, 8'h55);
    wb_read(0, 4'hC, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h required 00", v); end
    wb_write(0, REG_LENGTH, 8'd40);
    wb_read(0, REG_LENGTH, v);
    checks++; if (v !== 8'd15) begin errors++; $display("FAIL length_saturate got %0d required 15", v); end
  endtask

  task automatic test_basic();
    logic [7:0] v; logic [15:0] w;
    wb_write(0, REG_LENGTH, 8'd1);
    wb_write(0, REG_THRESHOLD, 8'd1);
    q = '{8'h41, 8'h42, 8'h00, 8'h41, 8'h43, 8'h00, 8'h01};
    load16(12'h400);
    wb_write(0, REG_CTRL, 8'h01);
    wait_done(0);
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'd0) begin errors++; $display("FAIL basic_distance got %0d required 0", v); end
    read16(0, REG_INDEX_HI, w);
    checks++; if (w !== 16'd0) begin errors++; $display("FAIL basic_index got %0d required 0", w); end
    read16(0, REG_MATCHES_HI, w);
    checks++; if (w !== 16'd2) begin errors++; $display("FAIL basic_matches got %0d required 2", w); end
    wb_read(0, REG_CTRL, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL basic_ctrl got %h required 02", v); end
  endtask

  task automatic test_second_word();
    logic [7:0] v; logic [15:0] w;
    wb_write(0, REG_THRESHOLD, 8'd0);
    q = '{8'h58, 8'h59, 8'h5A, 8'h57, 8'h00, 8'h41, 8'h42, 8'h00, 8'h01};
    load16(12'h400);
    wb_write(0, REG_CTRL, 8'h01);
    wait_done(0);
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'd0) begin errors++; $display("FAIL second_distance got %0d required 0", v); end
    read16(0, REG_INDEX_HI, w);
    checks++; if (w !== 16'd1) begin errors++; $display("FAIL second_index got %0d required 1", w); end
    read16(0, REG_MATCHES_HI, w);
    checks++; if (w !== 16'd1) begin errors++; $display("FAIL second_matches got %0d required 1", w); end
    // the unrelated word alone scores 4
    q = '{8'h58, 8'h59, 8'h5A, 8'h57, 8'h00, 8'h01};
    load16(12'h400);
    wb_write(0, REG_CTRL, 8'h01);
    wait_done(0);
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'd4) begin errors++; $display("FAIL xyzw_distance got %0d required 4", v); end
    read16(0, REG_MATCHES_HI, w);
    checks++; if (w !== 16'd0) begin errors++; $display("FAIL xyzw_matches got %0d required 0", w); end
  endtask

  task automatic test_tie();
    logic [7:0] v; logic [15:0] w;
    q = '{8'h41, 8'h43, 8'h00, 8'h42, 8'h42, 8'h00, 8'h01};
    load16(12'h400);
    wb_write(0, REG_CTRL, 8'h01);
    wait_done(0);
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'd1) begin errors++; $display("FAIL tie_distance got %0d required 1", v); end
    read16(0, REG_INDEX_HI, w);
    checks++; if (w !== 16'd0) begin errors++; $display("FAIL tie_index got %0d required 0", w); end
  endtask

  task automatic test_abort();
    logic [7:0] v;
    q = '{8'h58, 8'h59, 8'h5A, 8'h57, 8'h00, 8'h01};
    load16(12'h400);
    wb_write(0, REG_CTRL, 8'h01);
    repeat (6) @(negedge clk);
    wb_write(0, REG_CTRL, 8'h00);
    checks++; if (m16_cyc !== 1'b0) begin errors++; $display("FAIL abort_cyc got %b required 0", m16_cyc); end
    wb_read(0, REG_CTRL, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL abort_ctrl got %h required 00", v); end
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL abort_distance got %h required FF", v); end
  endtask

  task automatic test_error();
    logic [7:0] v; bit seen;
    seen = 0;
    q = '{8'h41, 8'h42, 8'h00, 8'h41, 8'h43, 8'h00, 8'h01};
    load16(12'h400);
    err_at16 = rd16 + 3;
    wb_write(0, REG_CTRL, 8'h01);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m16_err) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL error_injected err never driven, required 1"); end
    @(posedge clk); #1;
    checks++; if (m16_cyc !== 1'b0) begin errors++; $display("FAIL error_cyc got %b required 0", m16_cyc); end
    err_at16 = 0;
    wb_read(0, REG_CTRL, v);
    checks++; if (v !== 8'h04) begin errors++; $display("FAIL error_ctrl got %h required 04", v); end
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL error_distance got %h required FF", v); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v; logic [15:0] w; bit seen;
    seen = 0;
    wb_write(0, REG_CTRL, 8'h01);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m16_cyc && m16_adr >= 24'h200 && m16_adr < 24'h400) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL arst_vec_read never reached, required vector fetch"); end
    #2 rst = 1;
    #1;
    checks++; if (m16_cyc !== 1'b0) begin errors++; $display("FAIL arst_cyc got %b required 0", m16_cyc); end
    #1 rst = 0;
    wb_read(0, REG_CTRL, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL arst_ctrl got %h required 00", v); end
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL arst_distance got %h required FF", v); end
    wb_write(0, REG_LENGTH, 8'd1);
    wb_write(0, REG_THRESHOLD, 8'd1);
    wb_write(0, REG_CTRL, 8'h01);
    wait_done(0);
    wb_read(0, REG_DISTANCE, v);
    checks++; if (v !== 8'd0) begin errors++; $display("FAIL arst_rerun_distance got %0d required 0", v); end
    read16(0, REG_MATCHES_HI, w);
    checks++; if (w !== 16'd2) begin errors++; $display("FAIL arst_rerun_matches got %0d required 2", w); end
    wb_read(0, REG_CTRL, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL arst_rerun_ctrl got %h required 02", v); end
  endtask

  task automatic test_wide();
    logic [7:0] v; logic [15:0] w; logic [31:0] pv; int r0;
    // 32 distinct chars 0x60..0x7F, char i matches pattern position i only
    for (int i = 0; i < 32; i++) begin
      pv = 32'h1 << i;
      for (int j = 0; j < 4; j++) mem32[12'h200 + (8'h60 + i) * 4 + j] = pv[31 - 8*j -: 8];
      mem32[12'hA00 + i] = 8'(8'h60 + i);
    end
    mem32[12'hA20] = 8'h00;
    mem32[12'hA21] = 8'h01;
    wb_write(1, REG_LENGTH, 8'd40);
    wb_read(1, REG_LENGTH, v);
    checks++; if (v !== 8'd31) begin errors++; $display("FAIL wide_length_saturate got %0d required 31", v); end
    wb_write(1, REG_BASE_HI, 8'h00);
    wb_write(1, REG_BASE_MID, 8'h0A);
    wb_write(1, REG_BASE_LO, 8'h00);
    wb_read(1, REG_BASE_MID, v);
    checks++; if (v !== 8'h0A) begin errors++; $display("FAIL wide_dict_base got %h required 0A", v); end
    r0 = rd32;
    wb_write(1, REG_CTRL, 8'h01);
    wait_done(1);
    wb_read(1, REG_DISTANCE, v);
    checks++; if (v !== 8'd0) begin errors++; $display("FAIL wide_distance got %0d required 0", v); end
    read16(1, REG_MATCHES_HI, w);
    checks++; if (w !== 16'd1) begin errors++; $display("FAIL wide_matches got %0d required 1", w); end
    wb_read(1, REG_CTRL, v);
    checks++; if (v !== 8'h02) begin errors++; $display("FAIL wide_ctrl got %h required 02", v); end
    // 34 dictionary bytes + 32 chars x 4 vector bytes
    checks++; if (rd32 - r0 !== 162) begin errors++; $display("FAIL wide_read_count got %0d required 162", rd32 - r0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_second_word();
    test_tie();
    test_abort();
    test_error();
    test_async_reset();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
